// File: rtl/contador_ud_rango_2dig_pkg.sv
// rtl/contador_ud_rango_2dig_pkg.sv - shared select codes, timing defaults and BCD helper for the setting counters
package contador_ud_rango_2dig_pkg;

    localparam logic [3:0] SEL_SEG  = 4'd0;
    localparam logic [3:0] SEL_MIN  = 4'd1;
    localparam logic [3:0] SEL_HORA = 4'd2;
    localparam logic [3:0] SEL_DIA  = 4'd3;
    localparam logic [3:0] SEL_MES  = 4'd4;
    localparam logic [3:0] SEL_ANO  = 4'd5;

    // 100 MHz clock: 0.5 s before auto-repeat, then 10 steps per second
    localparam int DEF_HOLD_CYCLES   = 50_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;

    function automatic logic [7:0] bcd2(input int unsigned v);
        int unsigned t;
        int unsigned u;
        if (v > 99) begin
            return 8'd0;
        end
        t = v / 10;
        u = v % 10;
        return {t[3:0], u[3:0]};
    endfunction

endpackage

// File: rtl/contador_ud_rango_2dig_detector.sv
// rtl/contador_ud_rango_2dig_detector.sv - button edge tick plus hold-to-auto-repeat tick generator
module detector_flanco_repeticion #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic en,
    output logic tick
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_C   = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REPEAT_C = CW'(REPEAT_CYCLES);

    logic          btn_q;
    logic [CW-1:0] cnt;
    logic          repeating;
    logic          active;
    logic          edge_tick;
    logic          period_done;

    assign active    = btn & en;
    assign edge_tick = active & ~btn_q;

    always_comb begin
        period_done = 1'b0;
        if (repeating) begin
            period_done = (cnt == REPEAT_C);
        end else begin
            period_done = (cnt == HOLD_C);
        end
    end

    // cnt is 0 on the edge cycle, so the edge tick and a timer tick never coincide
    assign tick = edge_tick | (active & period_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q     <= btn;
            cnt       <= '0;
            repeating <= 1'b0;
        end else begin
            btn_q <= btn;
            if (!active) begin
                cnt       <= '0;
                repeating <= 1'b0;
            end else if (period_done) begin
                cnt       <= CW'(1);
                repeating <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/contador_ud_rango_2dig.sv
// rtl/contador_ud_rango_2dig.sv - two-digit up/down field counter with runtime upper bound, load, clamp and wrap pulses
module contador_ud_rango_2dig
    import contador_ud_rango_2dig_pkg::*;
#(
    parameter int W             = 7,
    parameter int MIN_VAL       = 0,
    parameter int SEL_CODE      = 5,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   en_count,
    input  logic         enUP,
    input  logic         enDOWN,
    input  logic [W-1:0] max_val,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic [3:0]   digit1,
    output logic [3:0]   digit0,
    output logic         wrap_up,
    output logic         wrap_down
);

    localparam logic [W-1:0] MIN_W = W'(MIN_VAL);

    logic         sel;
    logic         up_tick;
    logic         down_tick;
    logic [W-1:0] load_clamped;
    logic [7:0]   bcd;

    assign sel = (en_count == 4'(SEL_CODE));

    detector_flanco_repeticion #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_det_up (
        .clk   (clk),
        .reset (reset),
        .btn   (enUP),
        .en    (sel),
        .tick  (up_tick)
    );

    detector_flanco_repeticion #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_det_down (
        .clk   (clk),
        .reset (reset),
        .btn   (enDOWN),
        .en    (sel),
        .tick  (down_tick)
    );

    always_comb begin
        load_clamped = load_val;
        if (load_val < MIN_W) begin
            load_clamped = MIN_W;
        end else if (load_val > max_val) begin
            load_clamped = max_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value     <= MIN_W;
            wrap_up   <= 1'b0;
            wrap_down <= 1'b0;
        end else begin
            wrap_up   <= 1'b0;
            wrap_down <= 1'b0;
            if (load) begin
                value <= load_clamped;
            end else if (value > max_val) begin
                // bound dropped under us (e.g. day 31 when month becomes Feb)
                value <= max_val;
            end else if (up_tick && !down_tick) begin
                if (value == max_val) begin
                    value   <= MIN_W;
                    wrap_up <= 1'b1;
                end else begin
                    value <= value + W'(1);
                end
            end else if (down_tick && !up_tick) begin
                if (value == MIN_W) begin
                    value     <= max_val;
                    wrap_down <= 1'b1;
                end else begin
                    value <= value - W'(1);
                end
            end
        end
    end

    assign bcd    = bcd2(32'(value));
    assign digit1 = bcd[7:4];
    assign digit0 = bcd[3:0];

endmodule
